regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback.sv | 173 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Writer end of the integer register file. Merges ALU results
//               (always accepted, highest priority) and buffered LSU results
//               into the single registered write port W1, and keeps a
//               per-register busy scoreboard for decode operand stalls.
//               Optional macro WB_BYPASS_EN forwards the in-flight write to
//               decode and masks the matching busy indication.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int LSU_FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alu_valid_i,
   input  logic [ADDR_WIDTH-1:0] alu_rd_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   input  logic                  issue_valid_i,
   input  logic [ADDR_WIDTH-1:0] issue_rd_i,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   output logic                  busy_a_o,
   output logic                  busy_b_o,
   output logic                  fwd_valid_a_o,
   output logic                  fwd_valid_b_o,
   output logic [DATA_WIDTH-1:0] fwd_data_o,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o
);

   localparam int                 c_NREGS   = 1 << ADDR_WIDTH;
   localparam int                 c_PTR_W   = $clog2(LSU_FIFO_DEPTH);
   localparam int                 c_CNT_W   = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(LSU_FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   // LSU result buffer (storage is not reset; only pointers/count are)
   logic [ADDR_WIDTH-1:0] r_fifo_rd   [LSU_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [LSU_FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   // Result selection and registered write port
   logic                  w_sel_valid;
   logic [ADDR_WIDTH-1:0] w_sel_rd;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;

   // Scoreboard
   logic [c_NREGS-1:0]    r_busy;
   logic [c_NREGS-1:0]    w_set;
   logic [c_NREGS-1:0]    w_clr;
   logic                  w_sb_a;
   logic                  w_sb_b;

   // Ready depends on occupancy only, so a pop never frees a slot the same cycle
   assign w_full      = (r_count == c_FULL);
   assign w_empty     = (r_count == '0);
   assign lsu_ready_o = !w_full;
   assign w_push      = lsu_valid_i && !w_full;
   assign w_pop       = !alu_valid_i && !w_empty;

   // Pick this cycle's result: ALU first, then the oldest buffered load
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_rd    = '0;
      w_sel_data  = '0;
      if (alu_valid_i) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = alu_rd_i;
         w_sel_data  = alu_wdata_i;
      end else if (!w_empty) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = r_fifo_rd[r_rd_ptr];
         w_sel_data  = r_fifo_data[r_rd_ptr];
      end
   end

   // Buffer storage write
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= lsu_rd_i;
         r_fifo_data[r_wr_ptr] <= lsu_wdata_i;
      end
   end

   // Buffer pointers and occupancy; pointers wrap naturally (depth is 2**n)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Register the write port; results aimed at x0 are consumed but never written
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we    <= w_sel_valid && (w_sel_rd != '0);
         r_waddr <= w_sel_rd;
         r_wdata <= w_sel_data;
      end
   end

   assign we_a_o    = r_we;
   assign waddr_a_o = r_waddr;
   assign wdata_a_o = r_wdata;

   // Scoreboard set/clear vectors; x0 can never be set or written
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (issue_valid_i && (issue_rd_i != '0)) w_set[issue_rd_i] = 1'b1;
      if (r_we)                                w_clr[r_waddr]    = 1'b1;
   end

   // Scoreboard update: clear on retiring write, new issue overrides the clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign w_sb_a = r_busy[raddr_a_i] && (raddr_a_i != '0);
   assign w_sb_b = r_busy[raddr_b_i] && (raddr_b_i != '0);

`ifdef WB_BYPASS_EN
   // The retiring write can be consumed directly by decode this cycle
   assign fwd_valid_a_o = r_we && (r_waddr == raddr_a_i) && (raddr_a_i != '0);
   assign fwd_valid_b_o = r_we && (r_waddr == raddr_b_i) && (raddr_b_i != '0);
   assign fwd_data_o    = r_wdata;
`else
   assign fwd_valid_a_o = 1'b0;
   assign fwd_valid_b_o = 1'b0;
   assign fwd_data_o    = '0;
`endif

   assign busy_a_o = w_sb_a && !fwd_valid_a_o;
   assign busy_b_o = w_sb_b && !fwd_valid_b_o;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Self-checking bench for regfile_writeback. A queue/array
//               reference model predicts the write port, LSU ready, busy and
//               forward outputs every cycle; directed sequences pin literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          alu_valid_i = 1'b0;
   logic [AW-1:0] alu_rd_i = '0;
   logic [DW-1:0] alu_wdata_i = '0;
   logic          lsu_valid_i = 1'b0;
   logic          lsu_ready_o;
   logic [AW-1:0] lsu_rd_i = '0;
   logic [DW-1:0] lsu_wdata_i = '0;
   logic          issue_valid_i = 1'b0;
   logic [AW-1:0] issue_rd_i = '0;
   logic [AW-1:0] raddr_a_i = '0;
   logic [AW-1:0] raddr_b_i = '0;
   logic          busy_a_o, busy_b_o, fwd_valid_a_o, fwd_valid_b_o;
   logic [DW-1:0] fwd_data_o;
   logic [AW-1:0] waddr_a_o;
   logic [DW-1:0] wdata_a_o;
   logic          we_a_o;

   regfile_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_wdata_i(alu_wdata_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_rd_i(lsu_rd_i), .lsu_wdata_i(lsu_wdata_i),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .busy_a_o(busy_a_o), .busy_b_o(busy_b_o),
      .fwd_valid_a_o(fwd_valid_a_o), .fwd_valid_b_o(fwd_valid_b_o),
      .fwd_data_o(fwd_data_o),
      .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          m_q[$];
   logic [31:0]   m_busy  = '0;
   logic          m_we    = 1'b0;
   logic [AW-1:0] m_waddr = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            m_rdy, m_nwe;
   logic [AW-1:0] m_na;
   logic [DW-1:0] m_nd;
   ent_t          m_e, m_in;

   // Model step: one result retires per cycle, ALU wins, loads in arrival order
   always @(posedge clk_i or negedge rst_ni) begin : model
      if (!rst_ni) begin
         m_q.delete();
         m_busy  = '0;
         m_we    = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         m_rdy = (m_q.size() < DEPTH);
         m_nwe = 1'b0; m_na = '0; m_nd = '0;
         if (alu_valid_i) begin
            m_nwe = (alu_rd_i != 0); m_na = alu_rd_i; m_nd = alu_wdata_i;
         end else if (m_q.size() > 0) begin
            m_e   = m_q.pop_front();
            m_nwe = (m_e.rd != 0); m_na = m_e.rd; m_nd = m_e.d;
         end
         if (lsu_valid_i && m_rdy) begin
            m_in.rd = lsu_rd_i; m_in.d = lsu_wdata_i;
            m_q.push_back(m_in);
         end
         if (m_we) m_busy[m_waddr] = 1'b0;
         if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
         m_we = m_nwe; m_waddr = m_na; m_wdata = m_nd;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk_i) begin : compare
      logic efa, efb;
      efa = BYP && m_we && (m_waddr == raddr_a_i) && (raddr_a_i != 0);
      efb = BYP && m_we && (m_waddr == raddr_b_i) && (raddr_b_i != 0);
      chk("m.lsu_ready", lsu_ready_o, m_q.size() < DEPTH);
      chk("m.we", we_a_o, m_we);
      if (m_we) begin
         chk("m.waddr", waddr_a_o, m_waddr);
         chk("m.wdata", wdata_a_o, m_wdata);
      end
      chk("m.busy_a", busy_a_o, m_busy[raddr_a_i] && (raddr_a_i != 0) && !efa);
      chk("m.busy_b", busy_b_o, m_busy[raddr_b_i] && (raddr_b_i != 0) && !efb);
      chk("m.fwd_valid_a", fwd_valid_a_o, efa);
      chk("m.fwd_valid_b", fwd_valid_b_o, efb);
      if (!BYP || m_we) chk("m.fwd_data", fwd_data_o, BYP ? m_wdata : 32'd0);
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk_i); #1;
   endtask

   task automatic idle();
      alu_valid_i = 1'b0; lsu_valid_i = 1'b0; issue_valid_i = 1'b0;
   endtask

   int  t3_alu_v [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
   int  t3_lsu_v [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
   int  t3_lsu_rd[9] = '{20, 21, 22, 22, 22, 22, 0, 0, 0};
   int  t3_ready [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
   int  t3_we    [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
   int  t3_waddr [9] = '{0, 10, 11, 12, 13, 20, 21, 22, 0};
   logic hold;
   int   alu_pct;

   initial begin
      // reset state
      idle();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst.we", we_a_o, 0);
      chk("rst.waddr", waddr_a_o, 0);
      chk("rst.wdata", wdata_a_o, 0);
      chk("rst.lsu_ready", lsu_ready_o, 1);
      chk("rst.busy_a", busy_a_o, 0);
      nxt();
      rst_ni = 1'b1;

      // issue rd5, ALU result one cycle later
      issue_valid_i = 1'b1; issue_rd_i = 5; raddr_a_i = 5;
      @(negedge clk_i); chk("t1.busy_before_issue", busy_a_o, 0);
      nxt();
      issue_valid_i = 1'b0; alu_valid_i = 1'b1; alu_rd_i = 5; alu_wdata_i = 32'hDEADBEEF;
      @(negedge clk_i); chk("t1.busy_after_issue", busy_a_o, 1);
      nxt();
      idle();
      @(negedge clk_i);
      chk("t1.we", we_a_o, 1);
      chk("t1.waddr", waddr_a_o, 5);
      chk("t1.wdata", wdata_a_o, 32'hDEADBEEF);
      chk("t1.busy_during_write", busy_a_o, !BYP);
      nxt();
      @(negedge clk_i);
      chk("t1.we_after", we_a_o, 0);
      chk("t1.busy_cleared", busy_a_o, 0);
      nxt();

      // ALU and LSU in the same cycle
      alu_valid_i = 1'b1; alu_rd_i = 3; alu_wdata_i = 32'h33;
      lsu_valid_i = 1'b1; lsu_rd_i = 4; lsu_wdata_i = 32'h44;
      @(negedge clk_i); chk("t2.ready0", lsu_ready_o, 1);
      nxt();
      idle();
      @(negedge clk_i);
      chk("t2.ready1", lsu_ready_o, 1);
      chk("t2.alu_we", we_a_o, 1);
      chk("t2.alu_waddr", waddr_a_o, 3);
      chk("t2.alu_wdata", wdata_a_o, 32'h33);
      nxt();
      @(negedge clk_i);
      chk("t2.lsu_we", we_a_o, 1);
      chk("t2.lsu_waddr", waddr_a_o, 4);
      chk("t2.lsu_wdata", wdata_a_o, 32'h44);
      nxt();
      @(negedge clk_i); chk("t2.idle_we", we_a_o, 0);
      nxt();

      // ALU busy for 4 cycles while 3 loads arrive
      for (int c = 0; c < 9; c++) begin
         alu_valid_i = (t3_alu_v[c] != 0);
         alu_rd_i    = AW'(10 + c);
         alu_wdata_i = 32'hA000 + 32'(10 + c);
         lsu_valid_i = (t3_lsu_v[c] != 0);
         lsu_rd_i    = AW'(t3_lsu_rd[c]);
         lsu_wdata_i = 32'hB000 + 32'(t3_lsu_rd[c]);
         @(negedge clk_i);
         chk($sformatf("t3.ready[%0d]", c), lsu_ready_o, t3_ready[c]);
         chk($sformatf("t3.we[%0d]", c), we_a_o, t3_we[c]);
         if (t3_we[c] != 0) begin
            chk($sformatf("t3.waddr[%0d]", c), waddr_a_o, t3_waddr[c]);
            chk($sformatf("t3.wdata[%0d]", c), wdata_a_o,
                (t3_waddr[c] >= 20 ? 32'hB000 : 32'hA000) + 32'(t3_waddr[c]));
         end
         nxt();
      end
      idle();

      // x0 never busy, never written
      issue_valid_i = 1'b1; issue_rd_i = 0; raddr_a_i = 0;
      @(negedge clk_i); chk("t4.busy0_a", busy_a_o, 0);
      nxt();
      issue_valid_i = 1'b0; alu_valid_i = 1'b1; alu_rd_i = 0; alu_wdata_i = 32'h1234;
      @(negedge clk_i); chk("t4.busy0_b", busy_a_o, 0);
      nxt();
      idle();
      @(negedge clk_i);
      chk("t4.we", we_a_o, 0);
      chk("t4.busy0_c", busy_a_o, 0);
      nxt();

      // issue rd7 on the edge where a write to rd7 retires: set wins
      alu_valid_i = 1'b1; alu_rd_i = 7; alu_wdata_i = 32'h77;
      nxt();
      alu_valid_i = 1'b0; issue_valid_i = 1'b1; issue_rd_i = 7; raddr_b_i = 7;
      @(negedge clk_i);
      chk("t5.we", we_a_o, 1);
      chk("t5.waddr", waddr_a_o, 7);
      nxt();
      idle();
      @(negedge clk_i); chk("t5.busy7_kept", busy_b_o, 1);
      nxt();

      // async reset with a full buffer and busy bits set
      issue_valid_i = 1'b1; issue_rd_i = 8; raddr_a_i = 8;
      alu_valid_i = 1'b1; alu_rd_i = 1; alu_wdata_i = 32'hA001;
      lsu_valid_i = 1'b1; lsu_rd_i = 2; lsu_wdata_i = 32'hB002;
      nxt();
      issue_valid_i = 1'b0; lsu_rd_i = 3; lsu_wdata_i = 32'hB003;
      nxt();
      idle();
      chk("t6.full_before_reset", lsu_ready_o, 0);
      chk("t6.busy8_before_reset", busy_a_o, 1);
      #1 rst_ni = 1'b0;
      #1;
      chk("t6.we", we_a_o, 0);
      chk("t6.waddr", waddr_a_o, 0);
      chk("t6.wdata", wdata_a_o, 0);
      chk("t6.ready", lsu_ready_o, 1);
      chk("t6.busy_a", busy_a_o, 0);
      chk("t6.busy_b", busy_b_o, 0);
      nxt();
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i); chk($sformatf("t6.no_write[%0d]", c), we_a_o, 0);
         nxt();
      end

      // forward of an in-flight write to operand B
      issue_valid_i = 1'b1; issue_rd_i = 9;
      nxt();
      issue_valid_i = 1'b0; alu_valid_i = 1'b1; alu_rd_i = 9; alu_wdata_i = 32'h55;
      nxt();
      idle(); raddr_b_i = 9;
      @(negedge clk_i);
      chk("t7.fwd_valid_b", fwd_valid_b_o, BYP);
      chk("t7.fwd_data", fwd_data_o, BYP ? 32'h55 : 32'h0);
      chk("t7.busy_b", busy_b_o, !BYP);
      nxt();

      // randomized traffic, LSU holds its offer while stalled
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         hold = lsu_valid_i && !lsu_ready_o;
         @(posedge clk_i); #1;
         alu_pct       = (i < 1500) ? 8 : 3;
         alu_valid_i   = ($urandom_range(0, 9) < alu_pct);
         alu_rd_i      = AW'($urandom_range(0, 7));
         alu_wdata_i   = $urandom;
         if (!hold) begin
            lsu_valid_i = ($urandom_range(0, 1) == 1);
            lsu_rd_i    = AW'($urandom_range(0, 7));
            lsu_wdata_i = $urandom;
         end
         issue_valid_i = ($urandom_range(0, 9) < 3);
         issue_rd_i    = AW'($urandom_range(0, 7));
         raddr_a_i     = AW'($urandom_range(0, 7));
         raddr_b_i     = AW'($urandom_range(0, 7));
         if (i == 2000) begin
            #2 rst_ni = 1'b0;
            #3 rst_ni = 1'b1;
         end
      end
      idle();
      repeat (5) nxt();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
